param_datapath: RTL and testbench
=================================

Name: param_datapath

Overview:
Second-generation processor datapath, parametrised in data width, register count and stack depth. Contains:
- a register file with independent write and dual read ports;
- PC, IR and address register;
- an 8-operation ALU with a latched flags register;
- a real LIFO hardware stack with full/empty/error status, replacing the pointer-only stack.

It sits between the control unit, which drives all strobes and selects, and the data RAM, which supplies mem_rdata and receives addr.

Parameters:
DATA_W, 8, width of all data paths, registers, PC, IR and address register
NUM_REGS, 4, general-purpose registers (>=2); RA_W = clog2(NUM_REGS)
STACK_DEPTH, 8, stack entries (>=2); SP_W = clog2(STACK_DEPTH+1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
rf_we  in  1  write bus into rf[rf_waddr]
rf_waddr  in  RA_W  register-file write address
rf_raddr_a  in  RA_W  read port A select (ALU operand A, bus source)
rf_raddr_b  in  RA_W  read port B select (ALU operand B)
pc_inc  in  1  PC <= PC+1
pc_load  in  1  PC <= bus
ir_load  in  1  IR <= bus
ar_load  in  1  address register <= bus
flags_load  in  1  flags <= ALU flags
alu_op  in  3  ALU operation
bus_sel  in  2  bus source: 0 ALU, 1 rf port A, 2 mem_rdata, 3 stack_top
mem_rdata  in  DATA_W  data from RAM
push  in  1  push bus onto stack
pop  in  1  pop stack
dbg_sel  in  3  debug output select
bus  out  DATA_W  internal bus (combinational)
alu_out  out  DATA_W  ALU result (combinational)
pc_out  out  DATA_W  program counter
ir_out  out  DATA_W  instruction register
addr  out  DATA_W  address register
flags  out  4  {V,N,C,Z} latched
sp  out  SP_W  stack occupancy count
stack_top  out  DATA_W  top entry, 0 when empty
stack_full  out  1  sp==STACK_DEPTH
stack_empty  out  1  sp==0
stack_err  out  1  sticky over/underflow
dbg_out  out  DATA_W  debug view

Behaviour:
- Reset: all registers, PC, IR, addr, flags, sp and stack_err are 0 on the first rising edge with rst=1. Stack memory contents are don't-care. rst overrides all strobes.
- Loads: every register load takes bus at the rising edge, with 1-cycle latency. The bus is the value sampled in the same cycle, so read-modify-write into the same register is legal.
- PC: pc_load has priority over pc_inc. The increment wraps modulo 2^DATA_W.
- ALU: combinational on A=rf[raddr_a], B=rf[raddr_b].
  - Op encodings: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A, 7 SHR A (logical).
  - Z = result==0. N = result MSB.
  - C: ADD carry-out; SUB borrow (1 when A<B unsigned); SHL bit shifted out of MSB; SHR bit shifted out of LSB; 0 for logic ops.
  - V: signed overflow for ADD/SUB, 0 otherwise.
  - Flags update only when flags_load=1.
- Stack:
  - push only, not full: mem[sp] <= bus, sp+1.
  - pop only, not empty: sp-1.
  - push+pop, not empty: top overwritten with bus, sp unchanged.
  - push+pop, empty: behaves as push.
  - push when full (pop=0): ignored, stack_err <= 1.
  - pop when empty (push=0): ignored, stack_err <= 1.
  - stack_err clears only on rst.
  - stack_top = mem[sp-1], combinational. With bus_sel=3, pop and rf_we, the popped value is written into the register in the same cycle.
- Debug: dbg_sel selects 0 pc, 1 alu_out, 2 bus, 3 ir, 4 addr, 5 {flags zero-extended}, 6 stack_top, 7 rf[rf_raddr_b]. dbg_out is 0 while rst=1.
- Register-file write and stack operations in the same cycle are independent and both take effect.

Decomposition:
- Package datapath_pkg:
  - alu_op encodings;
  - bus_sel encodings;
  - flag bit indices (Z=0, C=1, N=2, V=3);
  - dbg_sel encodings.
- Sub-module param_stack (LIFO):
  - parameters DATA_W, STACK_DEPTH;
  - owns sp, memory, full/empty/err.
- ALU and register file stay inline.

Test Plan:
1. rst then rf_we with bus_sel=2, mem_rdata=0x7F into r0, 0x01 into r1; ADD with flags_load, written to r2 -> r2=0x80, flags V=1 N=1 C=0 Z=0.
2. SUB with r0=0x05, r1=0x05 and flags_load -> alu_out=0x00, Z=1, C=0; swap operands to r0=0x03, r1=0x05 -> 0xFE, C=1, N=1.
3. Push 0x11..0x18 (8 pushes) -> stack_full=1, sp=8; 9th push -> sp stays 8, stack_err=1, stack_top stays 0x18.
4. pop with bus_sel=3 and rf_we to r3 at top=0x18 -> r3=0x18, sp=7, stack_top=0x17; simultaneous push(0xAA)+pop -> sp=7, stack_top=0xAA.
5. pc_load and pc_inc together with bus=0x40 -> pc=0x40; then pc_inc from 0xFF -> pc=0x00.
6. Assert rst mid-stack-operation with sp=5 and stack_err=1 -> next edge sp=0, stack_empty=1, stack_err=0, stack_top=0, flags=0, dbg_out=0 during rst.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised datapath: ALU ops, bus sources,
// flag bit positions and debug-view selects.
package datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        BUS_ALU   = 2'd0,
        BUS_RF_A  = 2'd1,
        BUS_MEM   = 2'd2,
        BUS_STACK = 2'd3
    } bus_sel_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [2:0] {
        DBG_PC        = 3'd0,
        DBG_ALU       = 3'd1,
        DBG_BUS       = 3'd2,
        DBG_IR        = 3'd3,
        DBG_ADDR      = 3'd4,
        DBG_FLAGS     = 3'd5,
        DBG_STACK_TOP = 3'd6,
        DBG_RF_B      = 3'd7
    } dbg_sel_e;

endpackage

// File: rtl/param_datapath_if.sv
// Control-unit <-> datapath signal bundle; the control unit is the master,
// the datapath is the slave.
interface param_datapath_if
    import datapath_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 4,
    parameter int STACK_DEPTH = 8
);
    localparam int RA_W = $clog2(NUM_REGS);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [RA_W-1:0]   rf_raddr_a;
    logic [RA_W-1:0]   rf_raddr_b;
    logic              pc_inc;
    logic              pc_load;
    logic              ir_load;
    logic              ar_load;
    logic              flags_load;
    alu_op_e           alu_op;
    bus_sel_e          bus_sel;
    logic [DATA_W-1:0] mem_rdata;
    logic              push;
    logic              pop;
    dbg_sel_e          dbg_sel;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] ir_out;
    logic [DATA_W-1:0] addr;
    logic [3:0]        flags;
    logic [SP_W-1:0]   sp;
    logic [DATA_W-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;
    logic [DATA_W-1:0] dbg_out;

    modport master (
        output rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, pc_inc, pc_load,
               ir_load, ar_load, flags_load, alu_op, bus_sel, mem_rdata,
               push, pop, dbg_sel,
        input  bus, alu_out, pc_out, ir_out, addr, flags, sp, stack_top,
               stack_full, stack_empty, stack_err, dbg_out
    );

    modport slave (
        input  rf_we, rf_waddr, rf_raddr_a, rf_raddr_b, pc_inc, pc_load,
               ir_load, ar_load, flags_load, alu_op, bus_sel, mem_rdata,
               push, pop, dbg_sel,
        output bus, alu_out, pc_out, ir_out, addr, flags, sp, stack_top,
               stack_full, stack_empty, stack_err, dbg_out
    );

endinterface

// File: rtl/param_stack.sv
// LIFO hardware stack with occupancy count, full/empty status and a sticky
// over/underflow error bit.
module param_stack
    import datapath_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int STACK_DEPTH = 8,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [SP_W-1:0]   sp,
    output logic [DATA_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic              err
);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [DATA_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic              err_q;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              push_ok;
    logic              pop_ok;
    logic              replace;
    logic              fault;

    assign full    = (sp_q == SP_W'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign top_idx = IDX_W'(sp_q - SP_W'(1));

    // push+pop on a non-empty stack rewrites the top in place; on an empty
    // stack the pop is meaningless so the pair degrades to a plain push.
    assign replace = push && pop && !empty;
    assign push_ok = push && !full && !replace;
    assign pop_ok  = pop && !push && !empty;
    assign fault   = (push && !pop && full) || (pop && !push && empty);
    assign wr_idx  = replace ? top_idx : IDX_W'(sp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (push_ok)
                sp_q <= sp_q + SP_W'(1);
            else if (pop_ok)
                sp_q <= sp_q - SP_W'(1);
            if (fault)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (push_ok || replace))
            mem[wr_idx] <= din;
    end

    assign sp  = sp_q;
    assign err = err_q;
    assign top = empty ? '0 : mem[top_idx];

endmodule

// File: rtl/param_datapath.sv
// Parametrised processor datapath: register file, PC/IR/AR, 8-op ALU with
// latched flags, LIFO stack and a debug view mux.
module param_datapath
    import datapath_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int NUM_REGS    = 4,
    parameter  int STACK_DEPTH = 8,
    localparam int RA_W        = $clog2(NUM_REGS),
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    param_datapath_if.slave dp
);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ar_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   alu_wide;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        alu_flags;
    logic [DATA_W-1:0] bus_val;
    logic [DATA_W-1:0] dbg_val;
    logic [DATA_W-1:0] stack_top;
    logic [SP_W-1:0]   stack_sp;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    assign rd_a = rf[dp.rf_raddr_a];
    assign rd_b = rf[dp.rf_raddr_b];

    // Carry/borrow comes from the extra top bit of the widened sum/difference.
    always_comb begin
        alu_res  = '0;
        alu_wide = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (dp.alu_op)
            ALU_ADD: begin
                alu_wide = {1'b0, rd_a} + {1'b0, rd_b};
                alu_res  = alu_wide[MSB:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = (rd_a[MSB] == rd_b[MSB]) && (alu_res[MSB] != rd_a[MSB]);
            end
            ALU_SUB: begin
                alu_wide = {1'b0, rd_a} - {1'b0, rd_b};
                alu_res  = alu_wide[MSB:0];
                alu_c    = alu_wide[DATA_W];
                alu_v    = (rd_a[MSB] != rd_b[MSB]) && (alu_res[MSB] != rd_a[MSB]);
            end
            ALU_AND: alu_res = rd_a & rd_b;
            ALU_OR:  alu_res = rd_a | rd_b;
            ALU_XOR: alu_res = rd_a ^ rd_b;
            ALU_NOT: alu_res = ~rd_a;
            ALU_SHL: begin
                alu_res = rd_a << 1;
                alu_c   = rd_a[MSB];
            end
            ALU_SHR: begin
                alu_res = rd_a >> 1;
                alu_c   = rd_a[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_N] = alu_res[MSB];
        alu_flags[FLAG_V] = alu_v;
    end

    always_comb begin
        bus_val = '0;
        case (dp.bus_sel)
            BUS_ALU:   bus_val = alu_res;
            BUS_RF_A:  bus_val = rd_a;
            BUS_MEM:   bus_val = dp.mem_rdata;
            BUS_STACK: bus_val = stack_top;
            default:   bus_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= '0;
        end else if (dp.rf_we) begin
            rf[dp.rf_waddr] <= bus_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            ir_q    <= '0;
            ar_q    <= '0;
            flags_q <= '0;
        end else begin
            if (dp.pc_load)
                pc_q <= bus_val;
            else if (dp.pc_inc)
                pc_q <= pc_q + DATA_W'(1);
            if (dp.ir_load)
                ir_q <= bus_val;
            if (dp.ar_load)
                ar_q <= bus_val;
            if (dp.flags_load)
                flags_q <= alu_flags;
        end
    end

    param_stack #(
        .DATA_W      (DATA_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (dp.push),
        .pop   (dp.pop),
        .din   (bus_val),
        .sp    (stack_sp),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty),
        .err   (stack_err)
    );

    // Debug view is forced to zero while reset is held.
    always_comb begin
        dbg_val = '0;
        if (!rst) begin
            case (dp.dbg_sel)
                DBG_PC:        dbg_val = pc_q;
                DBG_ALU:       dbg_val = alu_res;
                DBG_BUS:       dbg_val = bus_val;
                DBG_IR:        dbg_val = ir_q;
                DBG_ADDR:      dbg_val = ar_q;
                DBG_FLAGS:     dbg_val = {{(DATA_W-4){1'b0}}, flags_q};
                DBG_STACK_TOP: dbg_val = stack_top;
                DBG_RF_B:      dbg_val = rd_b;
                default:       dbg_val = '0;
            endcase
        end
    end

    assign dp.bus         = bus_val;
    assign dp.alu_out     = alu_res;
    assign dp.pc_out      = pc_q;
    assign dp.ir_out      = ir_q;
    assign dp.addr        = ar_q;
    assign dp.flags       = flags_q;
    assign dp.sp          = stack_sp;
    assign dp.stack_top   = stack_top;
    assign dp.stack_full  = stack_full;
    assign dp.stack_empty = stack_empty;
    assign dp.stack_err   = stack_err;
    assign dp.dbg_out     = dbg_val;

endmodule

// File: tb/tb_param_datapath.sv
// Directed self-checking bench for param_datapath with hand-computed
// expectations for ALU, flags, PC, stack and reset behaviour.
module tb_param_datapath;
    import datapath_pkg::*;

    localparam int DATA_W      = 8;
    localparam int NUM_REGS    = 4;
    localparam int STACK_DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    param_datapath_if #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STACK_DEPTH(STACK_DEPTH)
    ) dp_if ();

    param_datapath #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dp  (dp_if)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearCtrl();
        dp_if.rf_we      = 1'b0;
        dp_if.rf_waddr   = '0;
        dp_if.rf_raddr_a = '0;
        dp_if.rf_raddr_b = '0;
        dp_if.pc_inc     = 1'b0;
        dp_if.pc_load    = 1'b0;
        dp_if.ir_load    = 1'b0;
        dp_if.ar_load    = 1'b0;
        dp_if.flags_load = 1'b0;
        dp_if.alu_op     = ALU_ADD;
        dp_if.bus_sel    = BUS_ALU;
        dp_if.mem_rdata  = '0;
        dp_if.push       = 1'b0;
        dp_if.pop        = 1'b0;
        dp_if.dbg_sel    = DBG_PC;
    endtask

    // One clock edge; strobes drop 1 time unit after it so each set of
    // strobes lasts exactly one cycle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearCtrl();
    endtask

    task automatic writeReg(input int idx, input logic [7:0] val);
        dp_if.rf_waddr  = 2'(idx);
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = val;
        dp_if.rf_we     = 1'b1;
        applyStimulus();
    endtask

    task automatic checkReg(input string tag, input int idx, input logic [7:0] expected);
        dp_if.rf_raddr_b = 2'(idx);
        dp_if.dbg_sel    = DBG_RF_B;
        #1;
        checkOutput(tag, 32'(dp_if.dbg_out), 32'(expected));
    endtask

    task automatic aluFlagged(input alu_op_e op);
        dp_if.rf_raddr_a = 2'd0;
        dp_if.rf_raddr_b = 2'd1;
        dp_if.alu_op     = op;
        dp_if.flags_load = 1'b1;
        #1;
    endtask

    alu_op_e     tblOp    [6] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR};
    logic [7:0]  tblAlu   [6] = '{8'h01, 8'h07, 8'h06, 8'hFC, 8'h06, 8'h01};
    logic [3:0]  tblFlags [6] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h2};

    initial begin
        rst = 1'b1;
        clearCtrl();
        dp_if.push = 1'b1;
        applyStimulus();
        checkOutput("reset_pc", 32'(dp_if.pc_out), 32'h0);
        checkOutput("reset_flags", 32'(dp_if.flags), 32'h0);
        checkOutput("reset_sp", 32'(dp_if.sp), 32'h0);
        checkOutput("reset_empty", 32'(dp_if.stack_empty), 32'h1);
        checkOutput("reset_err", 32'(dp_if.stack_err), 32'h0);
        checkOutput("reset_top", 32'(dp_if.stack_top), 32'h0);
        checkOutput("reset_dbg", 32'(dp_if.dbg_out), 32'h0);
        rst = 1'b0;

        // ADD overflow: 0x7F + 0x01
        writeReg(0, 8'h7F);
        writeReg(1, 8'h01);
        aluFlagged(ALU_ADD);
        dp_if.bus_sel  = BUS_ALU;
        dp_if.rf_waddr = 2'd2;
        dp_if.rf_we    = 1'b1;
        checkOutput("add_alu", 32'(dp_if.alu_out), 32'h80);
        checkOutput("add_bus", 32'(dp_if.bus), 32'h80);
        applyStimulus();
        checkOutput("add_flags", 32'(dp_if.flags), 32'hC);
        checkReg("add_r2", 2, 8'h80);
        dp_if.dbg_sel = DBG_FLAGS;
        #1;
        checkOutput("dbg_flags", 32'(dp_if.dbg_out), 32'h0C);

        // ADD carry-out to zero: 0xFF + 0x01
        writeReg(0, 8'hFF);
        aluFlagged(ALU_ADD);
        checkOutput("addc_alu", 32'(dp_if.alu_out), 32'h00);
        applyStimulus();
        checkOutput("addc_flags", 32'(dp_if.flags), 32'h3);

        // SUB equal and borrow
        writeReg(0, 8'h05);
        writeReg(1, 8'h05);
        aluFlagged(ALU_SUB);
        checkOutput("sub_eq_alu", 32'(dp_if.alu_out), 32'h00);
        applyStimulus();
        checkOutput("sub_eq_flags", 32'(dp_if.flags), 32'h1);
        writeReg(0, 8'h03);
        aluFlagged(ALU_SUB);
        checkOutput("sub_bor_alu", 32'(dp_if.alu_out), 32'hFE);
        applyStimulus();
        checkOutput("sub_bor_flags", 32'(dp_if.flags), 32'h6);

        // Logic and shift ops on r0=0x03, r1=0x05
        for (int i = 0; i < 6; i++) begin
            aluFlagged(tblOp[i]);
            checkOutput($sformatf("op%0d_alu", tblOp[i]), 32'(dp_if.alu_out), 32'(tblAlu[i]));
            applyStimulus();
            checkOutput($sformatf("op%0d_flags", tblOp[i]), 32'(dp_if.flags), 32'(tblFlags[i]));
        end

        // bus source = rf port A
        dp_if.rf_raddr_a = 2'd0;
        dp_if.bus_sel    = BUS_RF_A;
        #1;
        checkOutput("bus_rfa", 32'(dp_if.bus), 32'h03);
        applyStimulus();

        // SHL carry out of MSB, then SUB signed overflow 0x80 - 0x01
        writeReg(0, 8'h81);
        aluFlagged(ALU_SHL);
        checkOutput("shl_c_alu", 32'(dp_if.alu_out), 32'h02);
        applyStimulus();
        checkOutput("shl_c_flags", 32'(dp_if.flags), 32'h2);
        writeReg(0, 8'h80);
        writeReg(1, 8'h01);
        aluFlagged(ALU_SUB);
        checkOutput("sub_v_alu", 32'(dp_if.alu_out), 32'h7F);
        applyStimulus();
        checkOutput("sub_v_flags", 32'(dp_if.flags), 32'h8);

        // Fill the stack, then overflow
        for (int i = 0; i < STACK_DEPTH; i++) begin
            dp_if.bus_sel   = BUS_MEM;
            dp_if.mem_rdata = 8'(8'h11 + i);
            dp_if.push      = 1'b1;
            applyStimulus();
            checkOutput($sformatf("push%0d_sp", i), 32'(dp_if.sp), 32'(i + 1));
            checkOutput($sformatf("push%0d_top", i), 32'(dp_if.stack_top), 32'(8'h11 + i));
        end
        checkOutput("full_flag", 32'(dp_if.stack_full), 32'h1);
        checkOutput("full_err_before", 32'(dp_if.stack_err), 32'h0);
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'h99;
        dp_if.push      = 1'b1;
        applyStimulus();
        checkOutput("ovf_sp", 32'(dp_if.sp), 32'h8);
        checkOutput("ovf_err", 32'(dp_if.stack_err), 32'h1);
        checkOutput("ovf_top", 32'(dp_if.stack_top), 32'h18);

        // Pop into r3 through the bus, then push+pop replace
        dp_if.pop      = 1'b1;
        dp_if.bus_sel  = BUS_STACK;
        dp_if.rf_we    = 1'b1;
        dp_if.rf_waddr = 2'd3;
        #1;
        checkOutput("pop_bus", 32'(dp_if.bus), 32'h18);
        applyStimulus();
        checkOutput("pop_sp", 32'(dp_if.sp), 32'h7);
        checkOutput("pop_top", 32'(dp_if.stack_top), 32'h17);
        checkOutput("pop_full", 32'(dp_if.stack_full), 32'h0);
        checkReg("pop_r3", 3, 8'h18);
        dp_if.push      = 1'b1;
        dp_if.pop       = 1'b1;
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'hAA;
        applyStimulus();
        checkOutput("repl_sp", 32'(dp_if.sp), 32'h7);
        checkOutput("repl_top", 32'(dp_if.stack_top), 32'hAA);

        // IR and address register
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'h5A;
        dp_if.ir_load   = 1'b1;
        applyStimulus();
        checkOutput("ir_load", 32'(dp_if.ir_out), 32'h5A);
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'hC3;
        dp_if.ar_load   = 1'b1;
        applyStimulus();
        checkOutput("ar_load", 32'(dp_if.addr), 32'hC3);
        dp_if.dbg_sel = DBG_IR;
        #1;
        checkOutput("dbg_ir", 32'(dp_if.dbg_out), 32'h5A);

        // PC: load beats inc, increment, wrap
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'h40;
        dp_if.pc_load   = 1'b1;
        dp_if.pc_inc    = 1'b1;
        applyStimulus();
        checkOutput("pc_load_prio", 32'(dp_if.pc_out), 32'h40);
        dp_if.pc_inc = 1'b1;
        applyStimulus();
        checkOutput("pc_inc", 32'(dp_if.pc_out), 32'h41);
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'hFF;
        dp_if.pc_load   = 1'b1;
        applyStimulus();
        dp_if.pc_inc = 1'b1;
        applyStimulus();
        checkOutput("pc_wrap", 32'(dp_if.pc_out), 32'h00);

        // Down to sp=5, then reset mid-push
        dp_if.pop = 1'b1;
        applyStimulus();
        dp_if.pop = 1'b1;
        applyStimulus();
        checkOutput("pre_rst_sp", 32'(dp_if.sp), 32'h5);
        checkOutput("pre_rst_err", 32'(dp_if.stack_err), 32'h1);
        checkOutput("pre_rst_flags", 32'(dp_if.flags), 32'h8);
        rst             = 1'b1;
        dp_if.push      = 1'b1;
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'h77;
        dp_if.dbg_sel   = DBG_STACK_TOP;
        #1;
        checkOutput("rst_dbg_zero", 32'(dp_if.dbg_out), 32'h0);
        applyStimulus();
        checkOutput("rst_sp", 32'(dp_if.sp), 32'h0);
        checkOutput("rst_empty", 32'(dp_if.stack_empty), 32'h1);
        checkOutput("rst_err", 32'(dp_if.stack_err), 32'h0);
        checkOutput("rst_top", 32'(dp_if.stack_top), 32'h0);
        checkOutput("rst_flags", 32'(dp_if.flags), 32'h0);
        checkOutput("rst_ir", 32'(dp_if.ir_out), 32'h0);
        rst = 1'b0;
        checkReg("rst_r3", 3, 8'h00);

        // Underflow, then push+pop on empty acts as push
        dp_if.pop = 1'b1;
        applyStimulus();
        checkOutput("udf_sp", 32'(dp_if.sp), 32'h0);
        checkOutput("udf_err", 32'(dp_if.stack_err), 32'h1);
        dp_if.push      = 1'b1;
        dp_if.pop       = 1'b1;
        dp_if.bus_sel   = BUS_MEM;
        dp_if.mem_rdata = 8'h3C;
        applyStimulus();
        checkOutput("pp_empty_sp", 32'(dp_if.sp), 32'h1);
        checkOutput("pp_empty_top", 32'(dp_if.stack_top), 32'h3C);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
